// File: rtl/datapath_pkg.sv
// Shared types and constants for the single-cycle datapath fetch stage.
package datapath_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Halt cause encodings reported on halt_cause.
    localparam logic [1:0] HC_NONE  = 2'b00;
    localparam logic [1:0] HC_REQ   = 2'b01;
    localparam logic [1:0] HC_RANGE = 2'b10;
    localparam logic [1:0] HC_ALIGN = 2'b11;

    // Instruction width in bytes; the PC advances by this much.
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target mux with alignment and range flags for the fetch stage.
module next_pc_sel
    import datapath_pkg::*;
#(
    parameter int MEM_BYTES = 60
) (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc,
    output logic        misaligned,
    output logic        out_of_range
);

    // Highest legal fetch address: the last full word inside the memory.
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

    logic [31:0] branch_disp;

    // Signed word offset turned into a byte displacement; the add wraps mod 2^32.
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    // Target priority: register jump, absolute jump, branch, then fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg)
            next_pc = reg_target;
        else if (jump)
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + branch_disp;
    end

    assign misaligned   = (next_pc[1:0] != 2'b00);
    assign out_of_range = (next_pc > LAST_PC);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch sequencer; pc drives the instruction memory address,
// whose combinational read returns the word at pc in the same cycle.
module fetch_pc_unit
    import datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [15:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_d;
    logic [1:0]   cause_d;
    logic [15:0]  count_d;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         out_of_range;

    assign pc_plus4 = pc + 32'(INSTR_BYTES);

    next_pc_sel #(
        .MEM_BYTES(MEM_BYTES)
    ) u_next_pc_sel (
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .next_pc      (next_pc),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    // Next-state logic: halt beats stall, alignment beats range, HALT absorbs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cause_d = halt_cause;
        count_d = fetch_count;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    cause_d = HC_REQ;
                end else if (stall) begin
                    // hold everything
                end else if (misaligned) begin
                    state_d = ST_HALT;
                    cause_d = HC_ALIGN;
                end else if (out_of_range) begin
                    state_d = ST_HALT;
                    cause_d = HC_RANGE;
                end else begin
                    pc_d = next_pc;
                    if (fetch_count != 16'hFFFF)
                        count_d = fetch_count + 16'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc          <= RESET_PC;
            halt_cause  <= HC_NONE;
            fetch_count <= 16'd0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            halt_cause  <= cause_d;
            fetch_count <= count_d;
            fetch_valid <= (state_d == ST_RUN);
            halted      <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a behavioural model predicts the
// post-edge outputs for each driven cycle, and they are compared after the edge.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'd0;
    logic        jump_reg = 1'b0;
    logic [31:0] reg_target = 32'd0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, halted;
    logic [1:0]  halt_cause;
    logic [15:0] fetch_count;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg),
        .reg_target(reg_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .halted(halted), .halt_cause(halt_cause),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        hl;
        logic [1:0]  hc;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    // model state: 0 idle, 1 run, 2 halt
    int          m_st  = 0;
    logic [31:0] m_pc  = 32'd0;
    logic [1:0]  m_hc  = 2'b00;
    logic [15:0] m_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_edge(input logic r, st, hr, br, input logic [15:0] off,
                              input logic j, input logic [25:0] jt, input logic jr,
                              input logic [31:0] rt);
        logic [31:0] np;
        logic [31:0] p4;
        if (r) begin
            m_st = 0; m_pc = 32'd0; m_hc = 2'b00; m_cnt = 16'd0;
            return;
        end
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            p4 = m_pc + 32'd4;
            if (jr) np = rt;
            else if (j) np = {p4[31:28], jt, 2'b00};
            else if (br) np = p4 + 32'($signed(off) * 4);
            else np = p4;
            if (hr) begin
                m_st = 2; m_hc = 2'b01;
            end else if (!st) begin
                if (np % 4 != 0) begin
                    m_st = 2; m_hc = 2'b11;
                end else if (np > 32'd56) begin
                    m_st = 2; m_hc = 2'b10;
                end else begin
                    m_pc = np;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        end
    endtask

    // Drive one cycle, predict its outcome, then score the DUT after the edge.
    task automatic step(input logic r, st, hr, br, input logic [15:0] off,
                        input logic j, input logic [25:0] jt, input logic jr,
                        input logic [31:0] rt);
        exp_t e, o;
        @(negedge clk);
        reset = r; stall = st; halt_req = hr; branch_taken = br;
        branch_offset = off; jump = j; jump_target = jt; jump_reg = jr;
        reg_target = rt;
        model_edge(r, st, hr, br, off, j, jt, jr, rt);
        e.pc = m_pc; e.fv = (m_st == 1); e.hl = (m_st == 2); e.hc = m_hc; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            chk("pc", pc, o.pc);
            chk("pc_plus4", pc_plus4, o.pc + 32'd4);
            chk("fetch_valid", 32'(fetch_valid), 32'(o.fv));
            chk("halted", 32'(halted), 32'(o.hl));
            chk("halt_cause", 32'(halt_cause), 32'(o.hc));
            chk("fetch_count", 32'(fetch_count), 32'(o.cnt));
        end
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
    endtask

    task automatic rst_run();
        step(1, 0, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
        nop(); // IDLE -> RUN at pc 0
    endtask

    initial begin
        // Sequential fetch to the end of memory
        step(1, 0, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
        step(1, 0, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
        chk("reset_pc", pc, 32'd0);
        chk("reset_fv", 32'(fetch_valid), 32'd0);
        nop();
        chk("run_pc0", pc, 32'd0);
        chk("run_fv", 32'(fetch_valid), 32'd1);
        for (int i = 0; i < 14; i++) nop();
        chk("seq_last_pc", pc, 32'd56);
        nop();
        chk("range_halted", 32'(halted), 32'd1);
        chk("range_cause", 32'(halt_cause), 32'd2);
        chk("range_pc", pc, 32'd56);
        chk("range_cnt", 32'(fetch_count), 32'd14);

        // Branches back and forward
        rst_run();
        nop(); nop();
        step(0, 0, 0, 1, 16'hFFFE, 0, 26'd0, 0, 32'd0);
        chk("br_back", pc, 32'd4);
        nop();
        step(0, 0, 0, 1, 16'h0003, 0, 26'd0, 0, 32'd0);
        chk("br_fwd", pc, 32'd24);

        // Priority: jump over branch, jump_reg over both
        rst_run();
        nop(); nop(); nop();
        step(0, 0, 0, 1, 16'h0003, 1, 26'd5, 0, 32'd0);
        chk("jump_pri", pc, 32'd20);
        step(0, 0, 0, 1, 16'h0003, 1, 26'd5, 1, 32'd32);
        chk("jreg_pri", pc, 32'd32);

        // Misaligned register target
        step(0, 0, 0, 0, 16'd0, 0, 26'd0, 1, 32'h6);
        chk("align_cause", 32'(halt_cause), 32'd3);
        chk("align_pc", pc, 32'd32);
        chk("align_fv", 32'(fetch_valid), 32'd0);

        // Misaligned and out of range together: alignment wins
        rst_run();
        step(0, 0, 0, 0, 16'd0, 0, 26'd0, 1, 32'h0000_1002);
        chk("align_over_range", 32'(halt_cause), 32'd3);

        // Stall with branch held high
        rst_run();
        for (int i = 0; i < 4; i++) nop();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 16'h0003, 0, 26'd0, 0, 32'd0);
        chk("stall_pc", pc, 32'd16);
        chk("stall_cnt", 32'(fetch_count), 32'd4);
        nop();
        chk("stall_resume", pc, 32'd20);

        // Halt request with stall, then inputs ignored, then reset
        rst_run();
        nop(); nop();
        step(0, 1, 1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
        chk("req_cause", 32'(halt_cause), 32'd1);
        chk("req_pc", pc, 32'd8);
        step(0, 0, 1, 1, 16'h0001, 1, 26'd3, 1, 32'd4);
        step(0, 1, 0, 0, 16'd0, 1, 26'd1, 0, 32'd0);
        chk("halt_frozen", pc, 32'd8);
        step(1, 1, 0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);

        // Randomised mix against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 16'($signed($urandom_range(0, 8)) - 4),
                 ($urandom_range(0, 7) == 0),
                 26'($urandom_range(0, 16)),
                 ($urandom_range(0, 9) == 0),
                 32'($urandom_range(0, 66)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage of the single-cycle datapath. Holds the PC register, computes the next PC (sequential, branch, jump, jump-register), and drives the byte address into the 60-byte instruction memory, which returns the little-endian instruction word combinationally in the same cycle. Stops fetching cleanly on a halt request, an out-of-range target or a misaligned target, and reports the cause to the testbench and control.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `MEM_BYTES`, default 60: instruction memory size in bytes. The last legal fetch address is `MEM_BYTES-4` (56).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `stall`, input, 1: freezes the PC and the fetch count for this cycle.
- `halt_req`, input, 1: stop fetching; highest priority.
- `branch_taken`, input, 1: take the PC-relative branch.
- `branch_offset`, input, 16: signed word offset.
- `jump`, input, 1: absolute jump.
- `jump_target`, input, 26: word index of the jump target.
- `jump_reg`, input, 1: register-indirect jump.
- `reg_target`, input, 32: byte address for `jump_reg`.
- `pc`, output, 32: current PC; connects to the instruction memory `address`.
- `pc_plus4`, output, 32: `pc + 4`, combinational.
- `fetch_valid`, output, 1: the instruction word at `pc` is live this cycle.
- `halted`, output, 1: unit is in HALT.
- `halt_cause`, output, 2: `00` none, `01` request, `10` out of range, `11` misaligned.
- `fetch_count`, output, 16: number of retired fetches; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, HALT.
- **Reset state:** IDLE, `pc=RESET_PC`, `fetch_valid=0`, `halted=0`, `halt_cause=00`, `fetch_count=0`.
- **IDLE → RUN:** unconditional on the next edge. `fetch_valid` is 1 only in RUN.
- **next_pc selection, priority high to low:**
  - `jump_reg`: `reg_target`.
  - `jump`: `{pc_plus4[31:28], jump_target, 2'b00}`.
  - `branch_taken`: `pc_plus4 + (sext(branch_offset) << 2)`.
  - Otherwise: `pc_plus4`.
- All target arithmetic is 32-bit modulo 2^32; overflow wraps silently and is then range-checked.
- **RUN, per edge (first matching rule wins):**
  1. `halt_req`: go to HALT with cause `01`; `pc` holds.
  2. `stall`: hold `pc` and `fetch_count`; all other control inputs are ignored.
  3. `next_pc[1:0] != 0`: go to HALT with cause `11`; `pc` holds.
  4. `next_pc > MEM_BYTES-4`: go to HALT with cause `10`; `pc` holds.
  5. Otherwise: `pc <= next_pc` and `fetch_count` increments (saturating).
- The alignment check (rule 3) takes precedence over the range check (rule 4).
- **HALT:** absorbing. All inputs except `reset` are ignored; `pc`, `fetch_count` and `halt_cause` are frozen; `halted=1`, `fetch_valid=0`.
- **Reset in any state,** including mid-stall or in HALT: return to IDLE with the reset values on that edge.
- `halt_req` and `stall` asserted together: the halt wins.

## Timing
- `pc`, `halted`, `halt_cause`, `fetch_valid` and `fetch_count` are registered. `pc_plus4` is combinational from `pc`.
- All control inputs are sampled on the rising edge. Redirect latency is 1 cycle: the target appears on `pc` the cycle after `branch_taken`/`jump`/`jump_reg` is sampled.
- The instruction word is valid in the same cycle as `pc`, since the memory read is combinational.
- After reset deasserts: one IDLE cycle with `fetch_valid=0`, then RUN.
- HALT is entered one edge after the triggering condition and is observable on that same edge.

## Structure
- Shared package `datapath_pkg` holds:
  - the state enum (IDLE/RUN/HALT);
  - the halt-cause constants (`HC_NONE`, `HC_REQ`, `HC_RANGE`, `HC_ALIGN`);
  - `INSTR_BYTES = 4`.
- One combinational sub-module, `next_pc_sel`, implements the target mux and the alignment/range flags. The state machine and registers stay in `fetch_pc_unit`.
- Top-level connection: `fetch_pc_unit.pc` drives `address` of the instruction memory.

## Test plan
- **Sequential fetch:** reset high for 2 cycles, then low, no controls. Expect `pc` = 0, 0 (IDLE), 4, 8, …, 56. The next edge gives HALT with cause `10`, `pc=56`, `fetch_count=14`.
- **Branch:** at `pc=8`, `branch_taken=1`, `branch_offset=16'hFFFE`. Expect `pc=4` next cycle; offset `16'h0003` from `pc=8` gives `pc=24`.
- **Priority:** at `pc=12`, `jump=1`, `jump_target=5`, `branch_taken=1` together. Expect `pc=20`. Adding `jump_reg=1`, `reg_target=32` gives `pc=32`.
- **Misaligned target:** `jump_reg=1`, `reg_target=32'h0000_0006`. Expect HALT with cause `11`, `pc` unchanged, `fetch_valid=0`.
- **Stall:** hold `stall` for 3 cycles at `pc=16`, with `branch_taken` also high. Expect `pc=16` and `fetch_count` frozen; sequential fetch resumes to 20 afterwards.
- **Halt and reset:** `halt_req` together with `stall` at `pc=8` gives cause `01`. Inputs toggled in HALT produce no change. `reset` for 1 cycle returns `pc=0`, `halted=0`, `fetch_count=0`.
